fu_jump_sched: RTL and testbench
================================

Name: fu_jump_sched

Overview:
- Issue/arbitration controller for the single shared jump/branch functional unit (two-phase EN/finish handshake; result valid in the cycle finish is high).
- Accepts requests from NREQ reservation-station slots and grants one at a time, round-robin.
- Drives the FU, captures its result with the requester's tag, and holds it in a one-entry output buffer until the common data bus accepts it.
- Supports flush of in-flight and buffered work on mispredict.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAG_W, 3, width of destination/ROB tag carried with each op.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low.
- req  input  NREQ  per-requester request; held until granted.
- req_jalr  input  NREQ  per-requester: op is JALR (target base rs1).
- req_jal  input  NREQ  per-requester: unconditional jump (JAL/JALR), taken regardless of compare.
- req_cmp_ctrl  input  3*NREQ  per-requester compare select.
- req_rs1, req_rs2, req_imm, req_pc  input  32*NREQ each  per-requester operands, slot i at bits [32i+31:32i].
- req_tag  input  TAG_W*NREQ  per-requester tag.
- grant  output  NREQ  one-hot, one-cycle pulse; request accepted this cycle.
- flush  input  1  squash in-flight op and buffered result.
- fu_en  output  1  to FU EN.
- fu_jalr  output  1  to FU JALR.
- fu_cmp_ctrl  output  3  to FU compare select.
- fu_rs1, fu_rs2, fu_imm, fu_pc  output  32 each  FU operands.
- fu_finish  input  1  FU finish.
- fu_cmp_res  input  1  FU compare result.
- fu_pc_jump  input  32  FU target.
- fu_pc_wb  input  32  FU link value (PC+4).
- res_valid  output  1  result buffer full.
- res_ready  input  1  CDB accepts result this cycle.
- res_tag  output  TAG_W  tag of buffered result.
- res_taken  output  1  redirect required.
- res_pc_jump  output  32  target.
- res_pc_wb  output  32  link value.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, EXEC, HOLD. Reset (rst=0, asynchronous): state=IDLE, rr pointer=NREQ-1, res_valid=0, res_tag/res_taken/res_pc_*=0, squash flag=0.
- Reset mid-op: controller returns to IDLE immediately. Any stale fu_finish after reset is ignored because only EXEC samples it.
- Grant condition, evaluated combinationally:
  - no flush, any req set, and either state==IDLE or (state==HOLD and res_ready);
  - winner is the first set req scanning from (ptr+1) mod NREQ upward with wrap;
  - grant[winner]=1 and fu_en=1 for exactly that cycle;
  - fu_* operands are muxed from the winner, otherwise driven from slot 0 (don't-care) with fu_en=0;
  - ptr<=winner; state<=EXEC; the winner's jal flag and tag are latched internally.
- Never assert fu_en in two consecutive cycles; the FU treats EN while busy as a return to idle.
- EXEC: wait for fu_finish. On fu_finish with no squash:
  - capture res_tag, res_pc_jump, res_pc_wb, and res_taken = latched_jal | fu_cmp_res;
  - res_valid<=1; state<=HOLD.
  - On fu_finish with squash set: discard, clear squash, state<=IDLE.
- HOLD:
  - res_ready=1 clears res_valid (or re-enters EXEC via a same-cycle new grant, keeping res_valid 0 until the new finish);
  - res_ready=0 holds all res_* stable.
- Latency: grant in cycle T; fu_finish in T+1; res_valid=1 in T+2. Back-to-back throughput is one op per 2 cycles when res_ready stays high.
- Flush:
  - in IDLE: no effect and no grant;
  - in EXEC: set squash, state stays EXEC until finish, then IDLE;
  - in HOLD: res_valid<=0, state<=IDLE, no grant that cycle;
  - flush together with fu_finish in EXEC: result dropped.
- Flush with res_ready in the same cycle: flush wins, the result is not considered delivered, and the CDB must ignore it.
- grant never asserted while busy except the HOLD&res_ready case. A requester that withdraws req before grant is simply skipped.

Test Plan:
- Single op: reset, req[2]=1, jal=0, cmp=eq, rs1=rs2=5, pc=0x100, imm=0x20, tag=3 -> grant=0100 at T, fu_en at T, res_valid at T+2 with tag=3, taken=1, pc_jump=0x120, pc_wb=0x104.
- Round-robin: req=1111 held continuously with res_ready=1 -> grants 0001,0010,0100,1000,0001 every 2 cycles; no fu_en in adjacent cycles.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_* stable, no grant; res_ready=1 with req[1] pending -> same-cycle grant, res_valid drops next cycle.
- JALR not-taken compare: jal=1, jalr=1, rs1=0x2000, imm=8, compare false -> taken=1, pc_jump=0x2008.
- Flush in EXEC: flush one cycle after grant -> no res_valid; IDLE after finish; next req granted normally. Flush in HOLD -> res_valid=0 next cycle.
- Async reset: rst low mid-EXEC, between clock edges -> busy=0, res_valid=0 immediately; after release, ptr restart gives req=1111 first grant 0001.

Source files
------------

// File: rtl/fu_jump_sched_if.sv
// Bundle of requester, functional-unit and result-bus signals around the jump/branch scheduler.
// "master" is the scheduler side; "slave" is the surrounding pipeline (reservation station, FU, CDB).
interface fu_jump_sched_if #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 3
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_jalr;
  logic [NREQ-1:0]       req_jal;
  logic [3*NREQ-1:0]     req_cmp_ctrl;
  logic [32*NREQ-1:0]    req_rs1;
  logic [32*NREQ-1:0]    req_rs2;
  logic [32*NREQ-1:0]    req_imm;
  logic [32*NREQ-1:0]    req_pc;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic [NREQ-1:0]       grant;
  logic                  flush;

  logic                  fu_en;
  logic                  fu_jalr;
  logic [2:0]            fu_cmp_ctrl;
  logic [31:0]           fu_rs1;
  logic [31:0]           fu_rs2;
  logic [31:0]           fu_imm;
  logic [31:0]           fu_pc;
  logic                  fu_finish;
  logic                  fu_cmp_res;
  logic [31:0]           fu_pc_jump;
  logic [31:0]           fu_pc_wb;

  logic                  res_valid;
  logic                  res_ready;
  logic [TAG_W-1:0]      res_tag;
  logic                  res_taken;
  logic [31:0]           res_pc_jump;
  logic [31:0]           res_pc_wb;
  logic                  busy;

  modport master (
    input  req, req_jalr, req_jal, req_cmp_ctrl, req_rs1, req_rs2, req_imm, req_pc, req_tag, flush,
    input  fu_finish, fu_cmp_res, fu_pc_jump, fu_pc_wb, res_ready,
    output grant, fu_en, fu_jalr, fu_cmp_ctrl, fu_rs1, fu_rs2, fu_imm, fu_pc,
    output res_valid, res_tag, res_taken, res_pc_jump, res_pc_wb, busy
  );

  modport slave (
    output req, req_jalr, req_jal, req_cmp_ctrl, req_rs1, req_rs2, req_imm, req_pc, req_tag, flush,
    output fu_finish, fu_cmp_res, fu_pc_jump, fu_pc_wb, res_ready,
    input  grant, fu_en, fu_jalr, fu_cmp_ctrl, fu_rs1, fu_rs2, fu_imm, fu_pc,
    input  res_valid, res_tag, res_taken, res_pc_jump, res_pc_wb, busy
  );
endinterface

// File: rtl/fu_jump_sched.sv
// Round-robin issue controller for the shared jump/branch FU with a one-entry result buffer.
// Grant at T, FU finish at T+1, result valid at T+2; result held until res_ready, which also frees the next grant.
module fu_jump_sched #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 3
) (
  input logic             clk,
  input logic             rst,
  fu_jump_sched_if.master bus
);
  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             squash_q;
  logic             jal_q;
  logic [TAG_W-1:0] tag_q;
  logic             res_valid_q;
  logic             res_taken_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [31:0]      res_pc_jump_q;
  logic [31:0]      res_pc_wb_q;

  logic             win_found_d;
  logic [PTR_W-1:0] win_idx_d;
  logic [PTR_W-1:0] scan_d;
  logic             issue_d;
  logic             sel_jal_d;
  logic [TAG_W-1:0] sel_tag_d;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    scan_d      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_d = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!win_found_d && bus.req[scan_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = scan_d;
      end
    end
  end

  // A new op may only start when the FU is idle and the result buffer is (or is becoming) free.
  assign issue_d = !bus.flush && win_found_d &&
                   ((state_q == IDLE) || ((state_q == HOLD) && bus.res_ready));

  always_comb begin
    bus.grant       = '0;
    bus.fu_en       = issue_d;
    bus.fu_jalr     = bus.req_jalr[0];
    bus.fu_cmp_ctrl = bus.req_cmp_ctrl[2:0];
    bus.fu_rs1      = bus.req_rs1[31:0];
    bus.fu_rs2      = bus.req_rs2[31:0];
    bus.fu_imm      = bus.req_imm[31:0];
    bus.fu_pc       = bus.req_pc[31:0];
    sel_jal_d       = bus.req_jal[0];
    sel_tag_d       = bus.req_tag[TAG_W-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (issue_d && (win_idx_d == PTR_W'(i))) begin
        bus.grant[i]    = 1'b1;
        bus.fu_jalr     = bus.req_jalr[i];
        bus.fu_cmp_ctrl = bus.req_cmp_ctrl[3*i +: 3];
        bus.fu_rs1      = bus.req_rs1[32*i +: 32];
        bus.fu_rs2      = bus.req_rs2[32*i +: 32];
        bus.fu_imm      = bus.req_imm[32*i +: 32];
        bus.fu_pc       = bus.req_pc[32*i +: 32];
        sel_jal_d       = bus.req_jal[i];
        sel_tag_d       = bus.req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_W'(NREQ - 1);
      squash_q      <= 1'b0;
      jal_q         <= 1'b0;
      tag_q         <= '0;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_tag_q     <= '0;
      res_pc_jump_q <= '0;
      res_pc_wb_q   <= '0;
    end else begin
      if (issue_d) begin
        ptr_q <= win_idx_d;
        jal_q <= sel_jal_d;
        tag_q <= sel_tag_d;
      end
      case (state_q)
        IDLE: begin
          if (issue_d) state_q <= EXEC;
        end
        EXEC: begin
          // A flush landing on the finish cycle drops the result just like an earlier one.
          if (bus.fu_finish) begin
            if (squash_q || bus.flush) begin
              squash_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              res_tag_q     <= tag_q;
              res_taken_q   <= jal_q | bus.fu_cmp_res;
              res_pc_jump_q <= bus.fu_pc_jump;
              res_pc_wb_q   <= bus.fu_pc_wb;
              res_valid_q   <= 1'b1;
              state_q       <= HOLD;
            end
          end else if (bus.flush) begin
            squash_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.flush) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= issue_d ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_valid   = res_valid_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.res_taken   = res_taken_q;
  assign bus.res_pc_jump = res_pc_jump_q;
  assign bus.res_pc_wb   = res_pc_wb_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_fu_jump_sched.sv
// Directed bench for fu_jump_sched with a behavioural jump/branch FU of configurable latency.
module tb_fu_jump_sched;
  localparam int NREQ  = 4;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fu_jump_sched_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

  fu_jump_sched #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FU: samples operands on EN, raises finish fu_lat cycles later.
  int          fu_lat    = 1;
  int          fu_cnt    = 0;
  logic        fu_fin_q  = 1'b0;
  logic        fu_cmp_q  = 1'b0;
  logic [31:0] fu_jump_q = '0;
  logic [31:0] fu_wb_q   = '0;

  function automatic logic cmp_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    fu_fin_q <= 1'b0;
    if (fu_cnt > 0) begin
      fu_cnt <= fu_cnt - 1;
      if (fu_cnt == 1) fu_fin_q <= 1'b1;
    end
    if (bus.fu_en) begin
      fu_cmp_q  <= cmp_fn(bus.fu_cmp_ctrl, bus.fu_rs1, bus.fu_rs2);
      fu_jump_q <= bus.fu_jalr ? (bus.fu_rs1 + bus.fu_imm) : (bus.fu_pc + bus.fu_imm);
      fu_wb_q   <= bus.fu_pc + 32'd4;
      if (fu_lat <= 1) fu_fin_q <= 1'b1;
      else             fu_cnt   <= fu_lat - 1;
    end
  end

  assign bus.fu_finish  = fu_fin_q;
  assign bus.fu_cmp_res = fu_cmp_q;
  assign bus.fu_pc_jump = fu_jump_q;
  assign bus.fu_pc_wb   = fu_wb_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic jal, input logic jalr, input logic [2:0] cmp,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [TAG_W-1:0] tag);
    bus.req_jal[i]                  = jal;
    bus.req_jalr[i]                 = jalr;
    bus.req_cmp_ctrl[3*i +: 3]      = cmp;
    bus.req_rs1[32*i +: 32]         = rs1;
    bus.req_rs2[32*i +: 32]         = rs2;
    bus.req_imm[32*i +: 32]         = imm;
    bus.req_pc[32*i +: 32]          = pc;
    bus.req_tag[TAG_W*i +: TAG_W]   = tag;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    total++; if (bus.res_tag !== 3'd0) begin bad++; $display("FAIL reset_res_tag got=%0d exp=0", bus.res_tag); end
    total++; if (bus.res_pc_jump !== 32'h0) begin bad++; $display("FAIL reset_pc_jump got=%h exp=0", bus.res_pc_jump); end
    total++; if (bus.fu_en !== 1'b0) begin bad++; $display("FAIL reset_fu_en got=%b exp=0", bus.fu_en); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_slot(2, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 3'd3);
    bus.req = 4'b0100;
    #1;
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", bus.grant); end
    total++; if (bus.fu_en !== 1'b1) begin bad++; $display("FAIL single_fu_en got=%b exp=1", bus.fu_en); end
    total++; if (bus.fu_pc !== 32'h100 || bus.fu_imm !== 32'h20) begin bad++; $display("FAIL single_fu_ops got=%h/%h exp=100/20", bus.fu_pc, bus.fu_imm); end
    tick();
    bus.req = 4'b0000;
    #1;
    total++; if (bus.fu_en !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_exec got en=%b busy=%b exp en=0 busy=1", bus.fu_en, bus.busy); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", bus.res_valid); end
    tick();
    total++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 3'd3) begin bad++; $display("FAIL single_result got v=%b tag=%0d exp v=1 tag=3", bus.res_valid, bus.res_tag); end
    total++; if (bus.res_taken !== 1'b1) begin bad++; $display("FAIL single_taken got=%b exp=1", bus.res_taken); end
    total++; if (bus.res_pc_jump !== 32'h120 || bus.res_pc_wb !== 32'h104) begin bad++; $display("FAIL single_pcs got=%h/%h exp=120/104", bus.res_pc_jump, bus.res_pc_wb); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #1;
    total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_deliver got v=%b busy=%b exp 0/0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [2:0] exp_tag [5];
    exp_g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_tag = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    do_reset();
    for (int s = 0; s < NREQ; s++)
      set_slot(s, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h10, 32'h1000 * (s + 1), 3'(s + 2));
    bus.res_ready = 1'b1;
    bus.req       = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.grant !== exp_g[i] || bus.fu_en !== 1'b1) begin bad++; $display("FAIL rr_grant%0d got=%b en=%b exp=%b", i, bus.grant, bus.fu_en, exp_g[i]); end
      if (i > 0) begin
        total++; if (bus.res_valid !== 1'b1 || bus.res_tag !== exp_tag[i]) begin bad++; $display("FAIL rr_result%0d got v=%b tag=%0d exp tag=%0d", i, bus.res_valid, bus.res_tag, exp_tag[i]); end
      end
      tick();
      if (i == 4) bus.req = 4'b0000;
      total++; if (bus.fu_en !== 1'b0 || bus.grant !== 4'b0000) begin bad++; $display("FAIL rr_gap%0d got en=%b grant=%b exp 0", i, bus.fu_en, bus.grant); end
      tick();
    end
    tick();
    bus.res_ready = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_idle got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_backpressure();
    set_slot(3, 1'b0, 1'b0, 3'd1, 32'd7, 32'd7, 32'h40, 32'h300, 3'd5);
    bus.req = 4'b1000;
    #1;
    total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL bp_grant1 got=%b exp=1000", bus.grant); end
    tick();
    bus.req = 4'b0000;
    tick();
    set_slot(1, 1'b0, 1'b0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h500, 3'd6);
    bus.req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL bp_nogrant%0d got=%b exp=0000", c, bus.grant); end
      total++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 3'd5 || bus.res_taken !== 1'b0 || bus.res_pc_jump !== 32'h340) begin
        bad++; $display("FAIL bp_hold%0d got v=%b tag=%0d tk=%b pj=%h exp 1/5/0/340", c, bus.res_valid, bus.res_tag, bus.res_taken, bus.res_pc_jump);
      end
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    total++; if (bus.grant !== 4'b0010 || bus.fu_en !== 1'b1) begin bad++; $display("FAIL bp_release_grant got=%b en=%b exp=0010", bus.grant, bus.fu_en); end
    tick();
    bus.req = 4'b0000;
    #1;
    total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL bp_drop got v=%b busy=%b exp 0/1", bus.res_valid, bus.busy); end
    tick();
    total++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 3'd6 || bus.res_taken !== 1'b1 || bus.res_pc_jump !== 32'h510) begin
      bad++; $display("FAIL bp_second got v=%b tag=%0d tk=%b pj=%h exp 1/6/1/510", bus.res_valid, bus.res_tag, bus.res_taken, bus.res_pc_jump);
    end
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_jalr_and_branch();
    set_slot(0, 1'b1, 1'b1, 3'd0, 32'h2000, 32'd1, 32'd8, 32'h400, 3'd7);
    bus.req = 4'b0001;
    #1;
    total++; if (bus.grant !== 4'b0001 || bus.fu_jalr !== 1'b1) begin bad++; $display("FAIL jalr_grant got=%b jalr=%b exp=0001/1", bus.grant, bus.fu_jalr); end
    tick();
    bus.req = 4'b0000;
    tick();
    total++; if (bus.res_taken !== 1'b1 || bus.res_pc_jump !== 32'h2008 || bus.res_pc_wb !== 32'h404 || bus.res_tag !== 3'd7) begin
      bad++; $display("FAIL jalr_result got tk=%b pj=%h wb=%h tag=%0d exp 1/2008/404/7", bus.res_taken, bus.res_pc_jump, bus.res_pc_wb, bus.res_tag);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    set_slot(2, 1'b0, 1'b0, 3'd7, 32'd3, 32'd9, 32'h80, 32'h600, 3'd1);
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tick();
    total++; if (bus.res_valid !== 1'b1 || bus.res_taken !== 1'b0 || bus.res_pc_jump !== 32'h680 || bus.res_tag !== 3'd1) begin
      bad++; $display("FAIL branch_nt got v=%b tk=%b pj=%h tag=%0d exp 1/0/680/1", bus.res_valid, bus.res_taken, bus.res_pc_jump, bus.res_tag);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_flush();
    set_slot(1, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h4, 32'h700, 3'd2);
    bus.req   = 4'b0010;
    bus.flush = 1'b1;
    #1;
    total++; if (bus.grant !== 4'b0000 || bus.fu_en !== 1'b0) begin bad++; $display("FAIL flush_idle got grant=%b en=%b exp 0", bus.grant, bus.fu_en); end
    tick();
    bus.flush = 1'b0;
    #1;
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL flush_exec_grant got=%b exp=0010", bus.grant); end
    tick();
    bus.req   = 4'b0000;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL flush_on_finish got v=%b busy=%b exp 0/0", bus.res_valid, bus.busy); end

    fu_lat = 3;
    bus.req = 4'b0100;
    #1;
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL squash_grant got=%b exp=0100", bus.grant); end
    tick();
    bus.req   = 4'b0000;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL squash_wait got busy=%b exp=1", bus.busy); end
    tick();
    tick();
    total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL squash_drop got v=%b busy=%b exp 0/0", bus.res_valid, bus.busy); end
    fu_lat = 1;

    set_slot(3, 1'b0, 1'b0, 3'd0, 32'd1, 32'd1, 32'h8, 32'h800, 3'd4);
    bus.req = 4'b1000;
    #1;
    total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL flush_next_grant got=%b exp=1000", bus.grant); end
    tick();
    bus.req = 4'b0000;
    tick();
    total++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 3'd4) begin bad++; $display("FAIL flush_next_result got v=%b tag=%0d exp 1/4", bus.res_valid, bus.res_tag); end
    bus.flush     = 1'b1;
    bus.res_ready = 1'b1;
    bus.req       = 4'b0001;
    #1;
    total++; if (bus.grant !== 4'b0000 || bus.fu_en !== 1'b0) begin bad++; $display("FAIL flush_hold_nogrant got=%b en=%b exp 0", bus.grant, bus.fu_en); end
    tick();
    bus.flush     = 1'b0;
    bus.res_ready = 1'b0;
    #1;
    total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL flush_hold_clear got v=%b busy=%b exp 0/0", bus.res_valid, bus.busy); end
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL flush_hold_regrant got=%b exp=0001", bus.grant); end
    tick();
    bus.req = 4'b0000;
    tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.req = 4'b0010;
    #1;
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL areset_grant got=%b exp=0010", bus.grant); end
    tick();
    bus.req = 4'b0000;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL areset_exec got busy=%b exp=1", bus.busy); end
    #3;
    rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin bad++; $display("FAIL areset_now got busy=%b v=%b exp 0/0", bus.busy, bus.res_valid); end
    total++; if (bus.res_tag !== 3'd0 || bus.res_pc_jump !== 32'h0) begin bad++; $display("FAIL areset_regs got tag=%0d pj=%h exp 0/0", bus.res_tag, bus.res_pc_jump); end
    tick();
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.res_ready = 1'b1;
    #1;
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL areset_ptr got=%b exp=0001", bus.grant); end
    tick();
    bus.req = 4'b0000;
    tick();
    total++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 3'd7) begin bad++; $display("FAIL areset_result got v=%b tag=%0d exp 1/7", bus.res_valid, bus.res_tag); end
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.req          = '0;
    bus.req_jalr     = '0;
    bus.req_jal      = '0;
    bus.req_cmp_ctrl = '0;
    bus.req_rs1      = '0;
    bus.req_rs2      = '0;
    bus.req_imm      = '0;
    bus.req_pc       = '0;
    bus.req_tag      = '0;
    bus.flush        = 1'b0;
    bus.res_ready    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_jalr_and_branch();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
